// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one core load/store at a time,
// stalls WAIT_CYCLES, then returns a response with error flagging.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int BW   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BW);
  localparam int IDXW = $clog2(DEPTH);
  localparam int TOPW = OFFW + IDXW;
  localparam logic [DATA_WIDTH-1:0] OFF_MASK =
    DATA_WIDTH'(BW - 1);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be 0..15");
  end

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("dmem_responder: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic                  lat_write;
  logic [DATA_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BW-1:0]         lat_be;

  logic                  accept;
  logic                  access;
  logic                  acc_write;
  logic [DATA_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [BW-1:0]         acc_be;
  logic                  acc_misal;
  logic                  acc_oor;
  logic                  acc_err;
  logic [IDXW-1:0]       acc_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge,
  // so the live request feeds the RAM; otherwise the latched copy.
  assign acc_write = (state == IDLE) ? req_write : lat_write;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_be    = (state == IDLE) ? req_be    : lat_be;

  assign acc_misal = |(acc_addr & OFF_MASK);
  assign acc_oor   = |(acc_addr >> TOPW);
  assign acc_err   = acc_misal || acc_oor;
  assign acc_idx   = acc_addr[OFFW +: IDXW];

  // Next-state, wait counter and access strobe.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    access  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_n = RESP;
            access  = 1'b1;
          end else begin
            state_n = BUSY;
            cnt_n   = 4'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = RESP;
          access  = 1'b1;
          cnt_n   = 4'd0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, request latch and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (access) begin
        resp_err <= acc_err;
        if (!acc_write && !acc_err) begin
          resp_rdata <= mem[acc_idx];
        end else begin
          resp_rdata <= '0;
        end
      end else if (resp_valid && resp_ready) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Byte-lane RAM write; contents are never reset.
  always_ff @(posedge clk) begin
    if (access && !rst && acc_write && !acc_err) begin
      for (int i = 0; i < BW; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: one instance with zero and
// one with two wait states, both checked against a word-array model.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_err;

  logic [31:0] mem_m [2][1024];
  logic [3:0]  known [2][1024];

  int checks;
  int errors;

  dmem_responder #(
    .DATA_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)
  ) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(
    .DATA_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(2)
  ) u_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic junk(input int d);
    req_valid[d] = 1'b1;
    req_write[d] = 1'b1;
    req_addr[d]  = 32'h300 + 4 * $urandom_range(0, 7);
    req_wdata[d] = $urandom;
    req_be[d]    = 4'hF;
  endtask

  // Drive one request, measure latency, hold RESP for `hold`
  // cycles with junk on the request side, then handshake.
  task automatic txn(input int d, input bit wr,
                     input logic [31:0] addr, wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er);
    int lat;
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_be[d]     = be;
    resp_ready[d] = (hold == 0);
    chk("rdy_idle", 32'(req_ready[d]), 1);
    @(posedge clk); #1;
    junk(d);
    lat = 1;
    while (!resp_valid[d] && lat < 40) begin
      chk("rdy_busy", 32'(req_ready[d]), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (d == 0) ? 1 : 3);
    rd = resp_rdata[d];
    er = resp_err[d];
    chk("rdy_resp", 32'(req_ready[d]), 0);
    for (int i = 0; i < hold; i++) begin
      junk(d);
      @(posedge clk); #1;
      chk("hold_vld", 32'(resp_valid[d]), 1);
      chk("hold_data", resp_rdata[d], rd);
      chk("hold_err", 32'(resp_err[d]), 32'(er));
      chk("hold_rdy", 32'(req_ready[d]), 0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    chk("vld_clr", 32'(resp_valid[d]), 0);
    chk("data_clr", resp_rdata[d], 0);
    chk("err_clr", 32'(resp_err[d]), 0);
    chk("rdy_back", 32'(req_ready[d]), 1);
  endtask

  // Issue a request and check it against the word-array model.
  task automatic access(input int d, input bit wr,
                        input logic [31:0] addr, wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd);
    logic [31:0] r;
    logic        e;
    bit          bad;
    int          w;
    txn(d, wr, addr, wdata, be, hold, r, e);
    bad = (addr % 4 != 0) || (addr >= 32'h1000);
    chk("err", 32'(e), 32'(bad));
    w = int'(addr / 4) % 1024;
    if (bad) begin
      chk("err_data", r, 0);
    end else if (wr) begin
      chk("st_data", r, 0);
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_m[d][w][8*i +: 8] = wdata[8*i +: 8];
          known[d][w][i] = 1'b1;
        end
      end
    end else if (known[d][w] == 4'hF) begin
      chk("ld_data", r, mem_m[d][w]);
    end
    rd = r;
  endtask

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h200 + 4 * $urandom_range(0, 15)
                       + $urandom_range(1, 3);
    if (k == 1) return 32'h1000 + 4 * $urandom_range(0, 255);
    return 32'h200 + 4 * $urandom_range(0, 15);
  endfunction

  initial begin
    logic [31:0] r;
    checks = 0;
    errors = 0;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 1024; w++) begin
        known[d][w] = 4'h0;
        mem_m[d][w] = '0;
      end
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
    end
    req_valid  = '0;
    req_write  = '0;
    resp_ready = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'(req_ready[d]), 0);
      chk("rst_vld", 32'(resp_valid[d]), 0);
      chk("rst_data", resp_rdata[d], 0);
      chk("rst_err", 32'(resp_err[d]), 0);
    end
    rst = 1'b0;
    #1;
    chk("idle_rdy0", 32'(req_ready[0]), 1);
    chk("idle_rdy1", 32'(req_ready[1]), 1);
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      access(d, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, r);
      access(d, 0, 32'h10, 32'h0, 4'h0, 0, r);
      chk("full_ld", r, 32'hDEADBEEF);
      access(d, 1, 32'h10, 32'h000000AA, 4'h1, 0, r);
      access(d, 0, 32'h10, 32'h0, 4'hF, 0, r);
      chk("part_ld", r, 32'hDEADBEAA);
      access(d, 1, 32'h10, 32'h55555555, 4'h0, 0, r);
      access(d, 0, 32'h10, 32'h0, 4'h0, 0, r);
      chk("be0_ld", r, 32'hDEADBEAA);
      access(d, 0, 32'h13, 32'h0, 4'h0, 0, r);
      access(d, 0, 32'h1000, 32'h0, 4'h0, 0, r);
      access(d, 1, 32'h0, 32'h01020304, 4'hF, 0, r);
      access(d, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, r);
      access(d, 0, 32'h0, 32'h0, 4'h0, 0, r);
      chk("oor_st", r, 32'h01020304);
      access(d, 0, 32'h10, 32'h0, 4'h0, 5, r);
      chk("bp_ld", r, 32'hDEADBEAA);
    end

    access(1, 1, 32'h20, 32'hCAFEF00D, 4'hF, 0, r);
    req_valid[1]  = 1'b1;
    req_write[1]  = 1'b1;
    req_addr[1]   = 32'h20;
    req_wdata[1]  = 32'h12345678;
    req_be[1]     = 4'hF;
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("pre_rst_vld", 32'(resp_valid[1]), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(req_ready[1]), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_vld", 32'(resp_valid[1]), 0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_vld", 32'(resp_valid[1]), 0);
      chk("post_rst_rdy", 32'(req_ready[1]), 1);
    end
    access(1, 0, 32'h20, 32'h0, 4'h0, 0, r);
    chk("rst_no_wr", r, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      int d;
      int hold;
      d = $urandom_range(0, 1);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      access(d, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
             4'($urandom_range(0, 15)), hold, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
